noc_injector: RTL and testbench

Network interface stage directly upstream of each mesh node's `ifc_X_Y_to` injection port in the 4x4 NoC. It accepts one whole message from the local core (destination, length, up to MAX_BODY payload words) and serialises it into HEAD/BODY/TAIL flits. Flits are issued under credit-based flow control toward the router. One instance per node; 16 total in the mesh top.

---
 rtl/noc_pkg.sv | 56 +++++
 rtl/noc_injector_if.sv | 28 ++
 rtl/noc_injector_credit_counter.sv | 36 +++
 rtl/noc_injector.sv | 142 ++++++++++++++
 tb/tb_noc_injector.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit types, head-field layout and the head packing helper.
// Used by the injector, the routers and the ejector.
package noc_pkg;

  localparam int COORD_W    = 2;
  localparam int LEN_W      = 3;
  localparam int SEQ_W      = 8;
  localparam int NOC_DATA_W = 32;

  // Head fields occupy the top HEAD_W bits of the payload; offsets are within that slice.
  localparam int HEAD_W         = 4 * COORD_W + LEN_W + SEQ_W;
  localparam int HEAD_DST_X_LSB = HEAD_W - COORD_W;
  localparam int HEAD_DST_Y_LSB = HEAD_DST_X_LSB - COORD_W;
  localparam int HEAD_SRC_X_LSB = HEAD_DST_Y_LSB - COORD_W;
  localparam int HEAD_SRC_Y_LSB = HEAD_SRC_X_LSB - COORD_W;
  localparam int HEAD_LEN_LSB   = HEAD_SRC_Y_LSB - LEN_W;
  localparam int HEAD_SEQ_LSB   = HEAD_LEN_LSB - SEQ_W;

  typedef enum logic [1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef struct packed {
    flit_type_e                ftype;
    logic [NOC_DATA_W-1:0]     payload;
  } flit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY
  } inj_state_e;

  function automatic logic [HEAD_W-1:0] pack_head(
    input logic [COORD_W-1:0] dst_x,
    input logic [COORD_W-1:0] dst_y,
    input logic [COORD_W-1:0] src_x,
    input logic [COORD_W-1:0] src_y,
    input logic [LEN_W-1:0]   len,
    input logic [SEQ_W-1:0]   seq
  );
    logic [HEAD_W-1:0] h;
    h = '0;
    h[HEAD_DST_X_LSB +: COORD_W] = dst_x;
    h[HEAD_DST_Y_LSB +: COORD_W] = dst_y;
    h[HEAD_SRC_X_LSB +: COORD_W] = src_x;
    h[HEAD_SRC_Y_LSB +: COORD_W] = src_y;
    h[HEAD_LEN_LSB   +: LEN_W]   = len;
    h[HEAD_SEQ_LSB   +: SEQ_W]   = seq;
    return h;
  endfunction

endpackage

// File: rtl/noc_injector_if.sv
// Core-side message request plus router-side flit/credit channel of one injector.
interface noc_injector_if #(
  parameter int DATA_W   = 32,
  parameter int MAX_BODY = 4
);
  import noc_pkg::*;

  logic                         req_valid;
  logic                         req_ready;
  logic [COORD_W-1:0]           req_dst_x;
  logic [COORD_W-1:0]           req_dst_y;
  logic [LEN_W-1:0]             req_len;
  logic [DATA_W*MAX_BODY-1:0]   req_data;
  logic                         flit_valid;
  logic [DATA_W+1:0]            flit_data;
  logic                         credit_ret;

  modport master (
    output req_valid, req_dst_x, req_dst_y, req_len, req_data, credit_ret,
    input  req_ready, flit_valid, flit_data
  );

  modport slave (
    input  req_valid, req_dst_x, req_dst_y, req_len, req_data, credit_ret,
    output req_ready, flit_valid, flit_data
  );

endinterface

// File: rtl/noc_injector_credit_counter.sv
// Credit tracker for the router input buffer; a return and a consume in the same
// cycle cancel, and a return while already full is dropped.
module noc_credit_counter #(
  parameter int CREDITS = 4,
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             consume,
  input  logic             ret,
  output logic             has_credit,
  output logic [CNT_W-1:0] count
);

  assign has_credit = (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= CNT_W'(CREDITS);
    end else if (consume && !ret) begin
      count <= count - 1'b1;
    end else if (ret && !consume && (count != CNT_W'(CREDITS))) begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(ret && !consume && (count == CNT_W'(CREDITS))))
        else $error("credit return while credit counter already full");
      assert (!(consume && (count == '0)))
        else $error("flit consumed with no credit available");
    end
  end

endmodule

// File: rtl/noc_injector.sv
// Message-to-flit serialiser with credit flow control for one mesh node.
// Optional NOC_INJ_SEQ_EN adds an 8-bit head sequence counter (seq field is 0 otherwise).
module noc_injector
  import noc_pkg::*;
#(
  parameter int NODE_X   = 0,
  parameter int NODE_Y   = 0,
  parameter int DATA_W   = 32,
  parameter int MAX_BODY = 4,
  parameter int CREDITS  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  noc_injector_if.slave  bus,
  output logic           len_err
);

  localparam int IDX_W = (MAX_BODY > 1) ? $clog2(MAX_BODY) : 1;
  localparam int CNT_W = $clog2(CREDITS + 1);

  inj_state_e          state, state_nxt;
  logic [COORD_W-1:0]  dst_x_q, dst_y_q;
  logic [LEN_W-1:0]    len_q;
  logic [DATA_W-1:0]   body_q [MAX_BODY];
  logic [IDX_W-1:0]    idx;
  logic                accept, issue, has_credit, last_body, len_over;
  logic [LEN_W-1:0]    len_clamped;
  logic [CNT_W-1:0]    credit_cnt;
  logic [SEQ_W-1:0]    seq;
  flit_type_e          ftype_nxt;
  logic [DATA_W-1:0]   payload_nxt;

  assign bus.req_ready = (state == ST_IDLE);
  assign accept        = bus.req_valid && (state == ST_IDLE);
  assign len_over      = bus.req_len > LEN_W'(MAX_BODY);
  assign len_clamped   = len_over ? LEN_W'(MAX_BODY) : bus.req_len;
  assign last_body     = (LEN_W'(idx) + LEN_W'(1)) == len_q;

  noc_credit_counter #(
    .CREDITS (CREDITS),
    .CNT_W   (CNT_W)
  ) u_credit (
    .clk        (clk),
    .rst_n      (rst_n),
    .consume    (issue),
    .ret        (bus.credit_ret),
    .has_credit (has_credit),
    .count      (credit_cnt)
  );

`ifdef NOC_INJ_SEQ_EN
  logic [SEQ_W-1:0] seq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q <= '0;
    end else if (issue && (state == ST_HEAD)) begin
      seq_q <= seq_q + 1'b1;
    end
  end

  assign seq = seq_q;
`else
  assign seq = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_HEAD;
      ST_HEAD: if (has_credit) state_nxt = (len_q == '0) ? ST_IDLE : ST_BODY;
      ST_BODY: if (has_credit && last_body) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    issue       = 1'b0;
    ftype_nxt   = FLIT_HEAD;
    payload_nxt = '0;
    case (state)
      ST_HEAD: begin
        issue     = has_credit;
        ftype_nxt = (len_q == '0) ? FLIT_HEAD_TAIL : FLIT_HEAD;
        payload_nxt[DATA_W-1 -: HEAD_W] = pack_head(dst_x_q, dst_y_q, COORD_W'(NODE_X),
                                                    COORD_W'(NODE_Y), len_q, seq);
      end
      ST_BODY: begin
        issue       = has_credit;
        ftype_nxt   = last_body ? FLIT_TAIL : FLIT_BODY;
        payload_nxt = body_q[idx];
      end
      default: ;
    endcase
  end

  // Flit output register: flit_valid pulses once per issued flit; data holds between flits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.flit_valid <= 1'b0;
      bus.flit_data  <= '0;
      idx            <= '0;
      len_err        <= 1'b0;
    end else begin
      bus.flit_valid <= issue;
      if (issue) bus.flit_data <= {ftype_nxt, payload_nxt};
      if (accept) begin
        idx <= '0;
      end else if (issue && (state == ST_BODY)) begin
        idx <= idx + 1'b1;
      end
      if (accept && len_over) len_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      dst_x_q <= bus.req_dst_x;
      dst_y_q <= bus.req_dst_y;
      len_q   <= len_clamped;
      for (int i = 0; i < MAX_BODY; i++) begin
        body_q[i] <= bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (credit_cnt <= CNT_W'(CREDITS))
        else $error("credit count above buffer depth");
    end
  end

endmodule

// File: tb/tb_noc_injector.sv
// Directed bench for noc_injector at node (0,0), DATA_W=32, MAX_BODY=4, CREDITS=4.
module tb_noc_injector;

  logic clk = 1'b0;
  logic rst_n;
  logic len_err;
  int   errors = 0;
  int   checks = 0;
  int   seq_exp = 0;

  always #5 clk = ~clk;

  noc_injector_if #(.DATA_W(32), .MAX_BODY(4)) ifc ();

  noc_injector #(
    .NODE_X(0), .NODE_Y(0), .DATA_W(32), .MAX_BODY(4), .CREDITS(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ifc),
    .len_err (len_err)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_seq();
`ifdef NOC_INJ_SEQ_EN
    seq_exp = (seq_exp + 1) % 256;
`endif
  endtask

  function automatic logic [31:0] hp(input logic [31:0] base);
    return base | (32'(seq_exp) << 13);
  endfunction

  task automatic send(input logic [1:0] dx, input logic [1:0] dy,
                      input logic [2:0] len, input logic [127:0] data);
    ifc.req_dst_x = dx;
    ifc.req_dst_y = dy;
    ifc.req_len   = len;
    ifc.req_data  = data;
    ifc.req_valid = 1'b1;
    step();
    ifc.req_valid = 1'b0;
  endtask

  task automatic return_credits(input int n);
    ifc.credit_ret = 1'b1;
    repeat (n) step();
    ifc.credit_ret = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.req_valid = 1'b0; ifc.req_dst_x = '0; ifc.req_dst_y = '0;
    ifc.req_len = '0; ifc.req_data = '0; ifc.credit_ret = 1'b0;
    #23 rst_n = 1'b1;
    step();
    checks++; if (ifc.flit_valid !== 1'b0) begin errors++; $display("FAIL reset_flit_valid: got %b want 0", ifc.flit_valid); end
    checks++; if (ifc.flit_data !== 34'h0) begin errors++; $display("FAIL reset_flit_data: got %h want 0", ifc.flit_data); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %b want 0", len_err); end
    checks++; if (ifc.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", ifc.req_ready); end
    checks++; if (dut.u_credit.count !== 3'd4) begin errors++; $display("FAIL reset_credit: got %0d want 4", dut.u_credit.count); end
  endtask

  task automatic test_head_tail();
    logic [33:0] exp;
    send(2'd2, 2'd1, 3'd0, 128'h0);
    checks++; if (ifc.req_ready !== 1'b0) begin errors++; $display("FAIL ht_busy: got %b want 0", ifc.req_ready); end
    checks++; if (ifc.flit_valid !== 1'b0) begin errors++; $display("FAIL ht_latency: got %b want 0", ifc.flit_valid); end
    step();
    exp = {2'b11, hp(32'h9000_0000)};
    bump_seq();
    checks++; if (ifc.flit_valid !== 1'b1) begin errors++; $display("FAIL ht_valid: got %b want 1", ifc.flit_valid); end
    checks++; if (ifc.flit_data !== exp) begin errors++; $display("FAIL ht_data: got %h want %h", ifc.flit_data, exp); end
    checks++; if (dut.u_credit.count !== 3'd3) begin errors++; $display("FAIL ht_credit: got %0d want 3", dut.u_credit.count); end
    checks++; if (ifc.req_ready !== 1'b1) begin errors++; $display("FAIL ht_ready: got %b want 1", ifc.req_ready); end
    step();
    checks++; if (ifc.flit_valid !== 1'b0) begin errors++; $display("FAIL ht_single: got %b want 0", ifc.flit_valid); end
  endtask

  task automatic test_burst();
    logic [33:0] exp [4];
    return_credits(1);
    checks++; if (dut.u_credit.count !== 3'd4) begin errors++; $display("FAIL burst_refill: got %0d want 4", dut.u_credit.count); end
    send(2'd1, 2'd3, 3'd3, {32'h0, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
    exp[0] = {2'b00, hp(32'h7060_0000)};
    exp[1] = {2'b01, 32'hAAAA_0001};
    exp[2] = {2'b01, 32'hBBBB_0002};
    exp[3] = {2'b10, 32'hCCCC_0003};
    bump_seq();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ifc.flit_valid !== 1'b1 || ifc.flit_data !== exp[i]) begin
        errors++; $display("FAIL burst_flit%0d: got v=%b %h want v=1 %h", i, ifc.flit_valid, ifc.flit_data, exp[i]);
      end
    end
    checks++; if (dut.u_credit.count !== 3'd0) begin errors++; $display("FAIL burst_credit: got %0d want 0", dut.u_credit.count); end
    checks++; if (ifc.req_ready !== 1'b1) begin errors++; $display("FAIL burst_ready: got %b want 1", ifc.req_ready); end
    step();
    checks++; if (ifc.flit_valid !== 1'b0) begin errors++; $display("FAIL burst_end: got %b want 0", ifc.flit_valid); end
  endtask

  task automatic test_stall();
    logic [33:0] exp;
    return_credits(1);
    send(2'd0, 2'd0, 3'd2, {64'h0, 32'hEEEE_0005, 32'hDDDD_0004});
    step();
    exp = {2'b00, hp(32'h0040_0000)};
    bump_seq();
    checks++; if (ifc.flit_valid !== 1'b1 || ifc.flit_data !== exp) begin errors++; $display("FAIL stall_head: got v=%b %h want v=1 %h", ifc.flit_valid, ifc.flit_data, exp); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ifc.flit_valid !== 1'b0) begin errors++; $display("FAIL stall_wait%0d: got %b want 0", i, ifc.flit_valid); end
    end
    return_credits(1);
    checks++; if (ifc.flit_valid !== 1'b0 || dut.u_credit.count !== 3'd1) begin errors++; $display("FAIL stall_ret: got v=%b c=%0d want v=0 c=1", ifc.flit_valid, dut.u_credit.count); end
    step();
    exp = {2'b01, 32'hDDDD_0004};
    checks++; if (ifc.flit_valid !== 1'b1 || ifc.flit_data !== exp) begin errors++; $display("FAIL stall_body: got v=%b %h want v=1 %h", ifc.flit_valid, ifc.flit_data, exp); end
    step();
    checks++; if (ifc.flit_valid !== 1'b0) begin errors++; $display("FAIL stall_nodup: got %b want 0", ifc.flit_valid); end
    return_credits(1);
    step();
    exp = {2'b10, 32'hEEEE_0005};
    checks++; if (ifc.flit_valid !== 1'b1 || ifc.flit_data !== exp) begin errors++; $display("FAIL stall_tail: got v=%b %h want v=1 %h", ifc.flit_valid, ifc.flit_data, exp); end
    step();
    checks++; if (ifc.flit_valid !== 1'b0 || ifc.req_ready !== 1'b1) begin errors++; $display("FAIL stall_done: got v=%b r=%b want v=0 r=1", ifc.flit_valid, ifc.req_ready); end
  endtask

  task automatic test_simultaneous();
    logic [33:0] exp;
    return_credits(2);
    checks++; if (dut.u_credit.count !== 3'd2) begin errors++; $display("FAIL sim_pre: got %0d want 2", dut.u_credit.count); end
    send(2'd3, 2'd3, 3'd1, {96'h0, 32'hF00D_0006});
    return_credits(1);
    exp = {2'b00, hp(32'hF020_0000)};
    bump_seq();
    checks++; if (ifc.flit_valid !== 1'b1 || ifc.flit_data !== exp) begin errors++; $display("FAIL sim_head: got v=%b %h want v=1 %h", ifc.flit_valid, ifc.flit_data, exp); end
    checks++; if (dut.u_credit.count !== 3'd2) begin errors++; $display("FAIL sim_credit: got %0d want 2", dut.u_credit.count); end
    step();
    exp = {2'b10, 32'hF00D_0006};
    checks++; if (ifc.flit_data !== exp || dut.u_credit.count !== 3'd1) begin errors++; $display("FAIL sim_tail: got %h c=%0d want %h c=1", ifc.flit_data, dut.u_credit.count, exp); end
    step();
  endtask

  task automatic test_len_err();
    logic [33:0] exp [5];
    return_credits(3);
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL lenerr_pre: got %b want 0", len_err); end
    send(2'd1, 2'd0, 3'd6, {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_1000});
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL lenerr_set: got %b want 1", len_err); end
    exp[0] = {2'b00, hp(32'h4080_0000)};
    exp[1] = {2'b01, 32'h0000_1000};
    exp[2] = {2'b01, 32'h1111_0001};
    exp[3] = {2'b01, 32'h2222_0002};
    exp[4] = {2'b10, 32'h3333_0003};
    bump_seq();
    ifc.credit_ret = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ifc.flit_valid !== 1'b1 || ifc.flit_data !== exp[i]) begin
        errors++; $display("FAIL lenerr_flit%0d: got v=%b %h want v=1 %h", i, ifc.flit_valid, ifc.flit_data, exp[i]);
      end
    end
    ifc.credit_ret = 1'b0;
    step();
    checks++; if (ifc.flit_valid !== 1'b0) begin errors++; $display("FAIL lenerr_count: got %b want 0", ifc.flit_valid); end
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL lenerr_sticky: got %b want 1", len_err); end
    checks++; if (dut.u_credit.count !== 3'd4) begin errors++; $display("FAIL lenerr_credit: got %0d want 4", dut.u_credit.count); end
  endtask

`ifdef NOC_INJ_SEQ_EN
  task automatic test_seq();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    seq_exp = 0;
    for (int i = 0; i < 257; i++) begin
      send(2'd0, 2'd0, 3'd0, 128'h0);
      return_credits(1);
      checks++;
      if (ifc.flit_valid !== 1'b1 || ifc.flit_data[20:13] !== 8'(seq_exp)) begin
        errors++; $display("FAIL seq_msg%0d: got v=%b seq=%0d want v=1 seq=%0d", i, ifc.flit_valid, ifc.flit_data[20:13], seq_exp);
      end
      bump_seq();
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [33:0] exp;
    send(2'd2, 2'd2, 3'd3, {32'h0, 32'h3, 32'h2, 32'h1});
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ifc.flit_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", ifc.flit_valid); end
    checks++; if (dut.u_credit.count !== 3'd4) begin errors++; $display("FAIL rmid_credit: got %0d want 4", dut.u_credit.count); end
    checks++; if (ifc.req_ready !== 1'b1 || len_err !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: got r=%b e=%b want r=1 e=0", ifc.req_ready, len_err); end
    #1 rst_n = 1'b1;
    seq_exp = 0;
    step();
    send(2'd0, 2'd1, 3'd0, 128'h0);
    step();
    exp = {2'b11, 32'h1000_0000};
    checks++; if (ifc.flit_valid !== 1'b1 || ifc.flit_data !== exp) begin errors++; $display("FAIL rmid_after: got v=%b %h want v=1 %h", ifc.flit_valid, ifc.flit_data, exp); end
    step();
  endtask

  initial begin
    test_reset();
    test_head_tail();
    test_burst();
    test_stall();
    test_simultaneous();
    test_len_err();
`ifdef NOC_INJ_SEQ_EN
    test_seq();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
